dadda_mac_acc: RTL and testbench



---
 rtl/dadda_pkg.sv | 14 +
 rtl/dadda_mac_acc_if.sv | 32 +++
 rtl/dadda_acc_add.sv | 25 ++
 rtl/dadda_mac_acc.sv | 76 +++++++
 tb/tb_dadda_mac_acc.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/dadda_pkg.sv
// Shared definitions for the 8x8 Dadda multiplier wrapper and its
// multiply-accumulate back end: operand/product widths and FSM state encoding.
package dadda_pkg;

  localparam int PROD_W = 16;
  localparam int OPND_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dadda_mac_acc_if.sv
// Handshake bundle between a product source/result consumer (master) and the
// dadda_mac_acc accumulator (slave).
interface dadda_mac_acc_if
  import dadda_pkg::*;
#(
  parameter int PW    = PROD_W,
  parameter int AW    = 24,
  parameter int CNT_W = 8
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    prod;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    acc_out;
  logic             busy;
  logic             ovf;

  modport master (
    output start, len, in_valid, prod, out_ready,
    input  in_ready, out_valid, acc_out, busy, ovf
  );

  modport slave (
    input  start, len, in_valid, prod, out_ready,
    output in_ready, out_valid, acc_out, busy, ovf
  );

endinterface

// File: rtl/dadda_acc_add.sv
// Combinational AW-bit accumulate adder with carry-out. With DADDA_MAC_SAT_EN
// defined the sum clamps to all ones on carry; otherwise it wraps modulo 2^AW.
module dadda_acc_add #(
  parameter int AW = 24,
  parameter int PW = 16
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW:0] raw;

  assign raw   = {1'b0, acc} + (AW + 1)'(prod);
  assign carry = raw[AW];

`ifdef DADDA_MAC_SAT_EN
  // Once clamped, any further add carries again (or adds zero), so the clamp holds.
  assign sum = carry ? '1 : raw[AW-1:0];
`else
  assign sum = raw[AW-1:0];
`endif

endmodule

// File: rtl/dadda_mac_acc.sv
// Sequential multiply-accumulate back end: sums `len` products into a wide
// register and holds the total under a valid/ready handshake. Optional
// saturation is selected with DADDA_MAC_SAT_EN (see dadda_acc_add).
module dadda_mac_acc
  import dadda_pkg::*;
#(
  parameter int PW    = PROD_W,
  parameter int AW    = 24,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  dadda_mac_acc_if.slave bus
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    sum;
  logic             carry;
  logic             ovf_q;
  logic             accept;
  logic             launch;

  assign accept = (state == ACC) && bus.in_valid;
  assign launch = (state == IDLE) && bus.start;

  dadda_acc_add #(.AW(AW), .PW(PW)) u_add (
    .acc   (acc),
    .prod  (bus.prod),
    .sum   (sum),
    .carry (carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; rst is in the sensitivity list to act asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaulting state_nxt before the case keeps every path assigned, so no latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = (bus.len != '0) ? ACC : DONE;
      ACC:     if (accept && cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, remaining count and sticky overflow; start outside IDLE is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (launch) begin
      acc   <= '0;
      cnt   <= bus.len;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt - CNT_W'(1);
      if (carry) ovf_q <= 1'b1;
    end
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.acc_out   = acc;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Self-checking bench for dadda_mac_acc (AW=20): table vectors, hand-written
// corner sequences and randomized jobs against a plain-arithmetic sum model.
module tb_dadda_mac_acc;

  localparam int PW    = 16;
  localparam int AW    = 20;
  localparam int CNT_W = 8;
`ifdef DADDA_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dadda_mac_acc_if #(.PW(PW), .AW(AW), .CNT_W(CNT_W)) bus ();

  dadda_mac_acc #(.PW(PW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string         name;
    int            len;
    logic [PW-1:0] prod;
    int            gaps;
    logic [AW-1:0] exp_acc;
    bit            exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: true unsigned sum, overflow iff it reaches 2^AW.
  task automatic model(input logic [PW-1:0] prods[$], output logic [AW-1:0] acc, output bit ovf);
    longint total = 0;
    foreach (prods[i]) total += longint'(prods[i]);
    ovf = total >= (longint'(1) << AW);
    if (SAT && ovf) acc = '1;
    else            acc = AW'(total % (longint'(1) << AW));
  endtask

  // Launch a job from IDLE, feed products, check result, hold, then handshake.
  // gaps: 0 = in_valid always high, 1 = alternate 1/0, 2 = random.
  task automatic do_job(input string name, input int len, input logic [PW-1:0] prods[$],
                        input int gaps, input int hold, input bit poke_start,
                        input logic [AW-1:0] exp_acc, input bit exp_ovf);
    int   k = 0;
    int   guard = 0;
    logic stable = 1'b1;
    bus.start = 1'b1;
    bus.len   = CNT_W'(len);
    @(posedge clk); #1;
    bus.start = poke_start;
    check({name, " busy"}, bus.busy, 1);
    check({name, " in_ready"}, bus.in_ready, (len != 0));
    while (k < len && guard < 4000) begin
      case (gaps)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (guard % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.prod = prods[k];
      if (bus.in_valid && bus.in_ready) k++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    check({name, " accepts"}, k, len);
    check({name, " out_valid"}, bus.out_valid, 1);
    check({name, " acc_out"}, bus.acc_out, exp_acc);
    check({name, " ovf"}, bus.ovf, exp_ovf);
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.acc_out !== exp_acc) stable = 1'b0;
    end
    check({name, " held"}, stable, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check({name, " idle"}, bus.busy, 0);
    check({name, " out_valid low"}, bus.out_valid, 0);
    check({name, " acc_out kept"}, bus.acc_out, exp_acc);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[5];
    logic [PW-1:0] q[$];
    logic [AW-1:0] m_acc;
    bit            m_ovf;
    int            len;

    vecs[0] = '{"alt_valid",   4, 16'h0100, 1, 20'h00400, 1'b0};
    vecs[1] = '{"len_zero",    0, 16'h1234, 0, 20'h00000, 1'b0};
    vecs[2] = '{"single",      1, 16'hFFFF, 0, 20'h0FFFF, 1'b0};
    vecs[3] = '{"overflow17", 17, 16'hFE01, 0, SAT ? 20'hFFFFF : 20'h0DE11, 1'b1};
    vecs[4] = '{"full255",   255, 16'hFFFF, 2, SAT ? 20'hFFFFF : 20'hEFF01, 1'b1};

    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.prod = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset acc_out", bus.acc_out, 0);
    check("reset busy", bus.busy, 0);
    check("reset ovf", bus.ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic run with distinct products.
    q = '{16'hFE01, 16'h0001, 16'h0010};
    do_job("basic", 3, q, 0, 2, 1'b0, 20'h0FE12, 1'b0);

    // Table vectors: same product repeated len times.
    foreach (vecs[v]) begin
      q = {};
      repeat (vecs[v].len) q.push_back(vecs[v].prod);
      do_job(vecs[v].name, vecs[v].len, q, vecs[v].gaps, (v == 0) ? 5 : 1, 1'b0,
             vecs[v].exp_acc, vecs[v].exp_ovf);
    end

    // Start pulses in ACC and together with out_ready in DONE must be ignored.
    q = '{16'h0003, 16'h0005, 16'h0007};
    do_job("ign_start", 3, q, 0, 2, 1'b1, 20'h0000F, 1'b0);

    // Async reset in ACC after 2 of 5 accepts discards the run.
    bus.start = 1'b1; bus.len = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.prod = 16'h0042;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mid busy", bus.busy, 1);
    check("mid partial", bus.acc_out, 20'h00084);
    #2 rst = 1'b1;
    #1;
    check("rst in_ready", bus.in_ready, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst acc_out", bus.acc_out, 0);
    check("rst busy", bus.busy, 0);
    check("rst ovf", bus.ovf, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post rst busy", bus.busy, 0);
    check("post rst out_valid", bus.out_valid, 0);
    q = '{16'h0007};
    do_job("after_rst", 1, q, 0, 0, 1'b0, 20'h00007, 1'b0);

    // Randomized jobs against the arithmetic model.
    for (int r = 0; r < 20; r++) begin
      len = (r % 5 == 4) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 12));
      q = {};
      for (int i = 0; i < len; i++)
        q.push_back((r % 3 == 0) ? PW'($urandom_range(16'hF000, 16'hFFFF)) : PW'($urandom));
      model(q, m_acc, m_ovf);
      do_job($sformatf("rand%0d", r), len, q, 2, int'($urandom_range(0, 3)), r[0],
             m_acc, m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
